axi_receive_fifo: RTL



---
 rtl/axi_receive_fifo_if.sv | 29 ++
 rtl/axi_receive_fifo.sv | 127 ++++++++++++
 2 files changed

// File: rtl/axi_receive_fifo_if.sv
// Packet-in / word-out handshake bundle for axi_receive_fifo.
// The master side drives packets and pops words; the slave side is the FIFO.
interface axi_receive_fifo_if #(
  parameter int unsigned BUS_WIDTH  = 16,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  logic [BUS_WIDTH-1:0]  in_packet;
  logic                  in_valid;
  logic                  in_ready;
  logic                  is_addr;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_err;
  logic                  out_valid;
  logic                  out_ready;
  logic [LVL_W-1:0]      fill_level;

  modport master (
    output in_packet, in_valid, is_addr, out_ready,
    input  in_ready, out_data, out_err, out_valid, fill_level
  );

  modport slave (
    input  in_packet, in_valid, is_addr, out_ready,
    output in_ready, out_data, out_err, out_valid, fill_level
  );
endinterface

// File: rtl/axi_receive_fifo.sv
// Packet deserializer with optional byte-address to memory-ID conversion,
// feeding a first-word-fall-through output FIFO with ready/valid on both sides.
module axi_receive_fifo #(
  parameter int unsigned BUS_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned ADDR_BASE   = 'h100,
  parameter int unsigned STRIDE_LOG2 = 2,
  parameter int unsigned NUM_IDS     = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  axi_receive_fifo_if.slave bus
);
  localparam int unsigned PACKETS = (DATA_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
  localparam int unsigned CNT_W   = (PACKETS > 1) ? $clog2(PACKETS) : 1;
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned LVL_W   = PTR_W + 1;

  localparam logic [CNT_W-1:0]      LAST_BEAT  = CNT_W'(PACKETS - 1);
  localparam logic [LVL_W-1:0]      FULL_LVL   = LVL_W'(DEPTH);
  localparam logic [DATA_WIDTH-1:0] BASE_W     = DATA_WIDTH'(ADDR_BASE);
  localparam logic [DATA_WIDTH:0]   BASE_X     = (DATA_WIDTH + 1)'(ADDR_BASE);
  localparam logic [DATA_WIDTH:0]   LIMIT_X    = (DATA_WIDTH + 1)'(ADDR_BASE + (NUM_IDS << STRIDE_LOG2));
  localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = DATA_WIDTH'((1 << STRIDE_LOG2) - 1);
  localparam logic [DATA_WIDTH-1:0] BAD_ID     = DATA_WIDTH'(NUM_IDS);

  logic [CNT_W-1:0]      beat_cnt;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [LVL_W-1:0]      count;
  logic [DATA_WIDTH-1:0] mem_data [DEPTH];
  logic                  mem_err  [DEPTH];

  logic                  accept_c;
  logic                  last_c;
  logic                  push_c;
  logic                  pop_c;
  logic [DATA_WIDTH-1:0] word_c;
  logic [DATA_WIDTH:0]   word_x_c;
  logic [DATA_WIDTH-1:0] offset_c;
  logic                  addr_ok_c;
  logic [DATA_WIDTH-1:0] push_data_c;
  logic                  push_err_c;

  // in_ready depends only on registered state, never on out_ready.
  assign bus.in_ready   = (beat_cnt != LAST_BEAT) || (count < FULL_LVL);
  assign accept_c       = bus.in_valid && bus.in_ready;
  assign last_c         = (beat_cnt == LAST_BEAT);
  assign push_c         = accept_c && last_c && !flush;
  assign bus.out_valid  = (count != '0);
  assign pop_c          = bus.out_valid && bus.out_ready && !flush;
  assign bus.fill_level = count;
  assign bus.out_data   = bus.out_valid ? mem_data[rd_ptr] : '0;
  assign bus.out_err    = bus.out_valid && mem_err[rd_ptr];

  // Word assembly: earlier packets sit in the low slots, the live packet on top.
  if (PACKETS == 1) begin : g_single
    assign word_c = DATA_WIDTH'(bus.in_packet);
  end else begin : g_multi
    localparam int unsigned LO_W = (PACKETS - 1) * BUS_WIDTH;
    logic [LO_W-1:0] asm_buf;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        asm_buf <= '0;
      end else if (flush) begin
        asm_buf <= '0;
      end else if (accept_c && !last_c) begin
        asm_buf[int'(beat_cnt) * BUS_WIDTH +: BUS_WIDTH] <= bus.in_packet;
      end
    end

    assign word_c = DATA_WIDTH'({bus.in_packet, asm_buf});
  end

  // Address decode: in range and stride-aligned yields an ID, anything else NUM_IDS with err.
  always_comb begin
    word_x_c    = {1'b0, word_c};
    offset_c    = word_c - BASE_W;
    addr_ok_c   = (word_x_c >= BASE_X) && (word_x_c < LIMIT_X) && ((word_c & ALIGN_MASK) == '0);
    push_data_c = word_c;
    push_err_c  = 1'b0;
    if (bus.is_addr) begin
      push_data_c = addr_ok_c ? (offset_c >> STRIDE_LOG2) : BAD_ID;
      push_err_c  = !addr_ok_c;
    end
  end

  // Storage carries no reset; visibility is gated by count.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem_data[wr_ptr] <= push_data_c;
      mem_err[wr_ptr]  <= push_err_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else if (flush) begin
      beat_cnt <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
    end else begin
      if (accept_c) begin
        beat_cnt <= last_c ? '0 : beat_cnt + CNT_W'(1);
      end
      if (push_c) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      unique case ({push_c, pop_c})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end
endmodule
